// File: rtl/cache_ctrl_gen_if.sv
// ---------------------------------------------------------------------------
// cache_ctrl_gen_if
// Purpose : Groups the CPU request, tag-store status and cache/memory control
//           signals of the cache controller into one bundle.
// Params  : LINE_WORDS - words per cache line (sets the WordIdx width).
// Signals : Strobe, DRW     - CPU request valid / direction (1 = write)
//           M, V            - tag match and valid bit from the tag store
//           DReady          - request-complete pulse back to the CPU
//           W, WSel         - cache write enable / write-data source (1 = memory)
//           MStrobe, MRW    - memory request pulse / direction (1 = write)
//           RSel            - CPU read-data source (1 = memory path)
//           WordIdx         - word offset of the current refill beat
//           Busy            - controller not idle
// Modports: master - CPU/tag-store side; slave - cache controller side.
// ---------------------------------------------------------------------------
interface cache_ctrl_gen_if #(
  parameter int LINE_WORDS = 4
);
  localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  logic          Strobe;
  logic          DRW;
  logic          M;
  logic          V;
  logic          DReady;
  logic          W;
  logic          MStrobe;
  logic          MRW;
  logic          RSel;
  logic          WSel;
  logic [IW-1:0] WordIdx;
  logic          Busy;

  modport master (
    output Strobe, DRW, M, V,
    input  DReady, W, MStrobe, MRW, RSel, WSel, WordIdx, Busy
  );

  modport slave (
    input  Strobe, DRW, M, V,
    output DReady, W, MStrobe, MRW, RSel, WSel, WordIdx, Busy
  );
endinterface

// File: rtl/cache_ctrl_gen.sv
// ---------------------------------------------------------------------------
// cache_ctrl_gen
// Purpose : Write-through cache controller FSM. Read hits complete in one
//           cycle; read misses refill LINE_WORDS words, each beat being one
//           memory request followed by WAIT_CYCLES wait states; writes go to
//           memory and update the cache only on a hit.
// Params  : WAIT_CYCLES - memory wait states per access (1..255)
//           LINE_WORDS  - words refilled per read miss (power of two, 1..16)
// Ports   : clk   - clock, rising edge
//           reset - asynchronous active-low reset
//           bus   - cache_ctrl_gen_if.slave (request, tag status, controls)
// Macro   : WRITE_ALLOCATE_EN - when defined, a write miss first refills the
//           line, writes the CPU word into it (WALLOC) and then replays the
//           write, which now hits. Undefined: write-around on a miss.
// ---------------------------------------------------------------------------
module cache_ctrl_gen #(
  parameter int WAIT_CYCLES = 4,
  parameter int LINE_WORDS  = 4
) (
  input  logic             clk,
  input  logic             reset,
  cache_ctrl_gen_if.slave  bus
);
  localparam int            IW        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(LINE_WORDS - 1);
  localparam logic [7:0]    WAIT_LOAD = 8'(WAIT_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_READ  = 4'd1,
    S_RMISS = 4'd2,
    S_RMEM  = 4'd3,
    S_RDATA = 4'd4,
    S_RDONE = 4'd5,
    S_WRITE = 4'd6,
    S_WMEM  = 4'd7,
`ifdef WRITE_ALLOCATE_EN
    S_WDONE = 4'd8,
    S_WALLOC = 4'd9
`else
    S_WDONE = 4'd8
`endif
  } state_t;

  state_t        state_r, state_s;
  logic [7:0]    cnt_r, cnt_s;
  logic [IW-1:0] idx_r, idx_s;
`ifdef WRITE_ALLOCATE_EN
  logic          alloc_r, alloc_s;
`endif

  logic hit_s;
  logic dready_s, w_s, mstrobe_s, mrw_s, rsel_s, wsel_s;

  assign hit_s = bus.M & bus.V;

  // State, wait counter, refill index and allocate flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 8'd0;
      idx_r   <= '0;
`ifdef WRITE_ALLOCATE_EN
      alloc_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
`ifdef WRITE_ALLOCATE_EN
      alloc_r <= alloc_s;
`endif
    end
  end

  // Next-state logic and state-decoded control outputs.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
`ifdef WRITE_ALLOCATE_EN
    alloc_s   = alloc_r;
`endif
    dready_s  = 1'b0;
    w_s       = 1'b0;
    mstrobe_s = 1'b0;
    mrw_s     = 1'b0;
    rsel_s    = 1'b0;
    wsel_s    = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (bus.Strobe) begin
          state_s = bus.DRW ? S_WRITE : S_READ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ: begin
        if (hit_s) begin
          dready_s = 1'b1;
          state_s  = S_IDLE;
        end else begin
          idx_s    = '0;
          state_s  = S_RMISS;
        end
      end
      S_RMISS: begin
        mstrobe_s = 1'b1;
        cnt_s     = WAIT_LOAD;
        state_s   = S_RMEM;
      end
      S_RMEM: begin
        // Leave on the cycle the counter steps to zero: WAIT_CYCLES cycles here.
        cnt_s = cnt_r - 8'd1;
        if (cnt_r <= 8'd1) begin
          state_s = S_RDATA;
        end else begin
          state_s = S_RMEM;
        end
      end
      S_RDATA: begin
        w_s    = 1'b1;
        wsel_s = 1'b1;
        if (idx_r == LAST_IDX) begin
`ifdef WRITE_ALLOCATE_EN
          state_s = alloc_r ? S_WALLOC : S_RDONE;
`else
          state_s = S_RDONE;
`endif
        end else begin
          idx_s   = idx_r + IW'(1);
          state_s = S_RMISS;
        end
      end
      S_RDONE: begin
        dready_s = 1'b1;
        rsel_s   = 1'b1;
        state_s  = S_IDLE;
      end
      S_WRITE: begin
`ifdef WRITE_ALLOCATE_EN
        if (hit_s) begin
          w_s       = 1'b1;
          mstrobe_s = 1'b1;
          mrw_s     = 1'b1;
          cnt_s     = WAIT_LOAD;
          state_s   = S_WMEM;
        end else begin
          // Miss: refill the line first; the memory write is replayed later.
          alloc_s   = 1'b1;
          idx_s     = '0;
          state_s   = S_RMISS;
        end
`else
        w_s       = hit_s;
        mstrobe_s = 1'b1;
        mrw_s     = 1'b1;
        cnt_s     = WAIT_LOAD;
        state_s   = S_WMEM;
`endif
      end
      S_WMEM: begin
        mrw_s = 1'b1;
        cnt_s = cnt_r - 8'd1;
        if (cnt_r <= 8'd1) begin
          state_s = S_WDONE;
        end else begin
          state_s = S_WMEM;
        end
      end
      S_WDONE: begin
        dready_s = 1'b1;
        state_s  = S_IDLE;
      end
`ifdef WRITE_ALLOCATE_EN
      S_WALLOC: begin
        w_s     = 1'b1;
        wsel_s  = 1'b0;
        alloc_s = 1'b0;
        state_s = S_WRITE;
      end
`endif
      default: begin
        state_s = S_IDLE;
        cnt_s   = 8'd0;
        idx_s   = '0;
      end
    endcase
  end

  assign bus.DReady  = dready_s;
  assign bus.W       = w_s;
  assign bus.MStrobe = mstrobe_s;
  assign bus.MRW     = mrw_s;
  assign bus.RSel    = rsel_s;
  assign bus.WSel    = wsel_s;
  assign bus.WordIdx = idx_r;
  assign bus.Busy    = (state_r != S_IDLE);

endmodule

// File: tb/tb_cache_ctrl_gen.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl_gen
// Purpose : Self-checking bench for cache_ctrl_gen. Expected output traces are
//           computed per transaction from cycle arithmetic (latency formulas
//           and refill beat period), with random M/V/Strobe noise in cycles
//           where those inputs must be ignored.
// ---------------------------------------------------------------------------
module tb_cache_ctrl_gen;
  localparam int WAIT_CYCLES = 4;
  localparam int LINE_WORDS  = 4;
  localparam int IW          = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int P           = WAIT_CYCLES + 2;        // cycles per refill beat
  localparam int R_END       = 1 + LINE_WORDS * P;     // last refill cycle
`ifdef WRITE_ALLOCATE_EN
  localparam bit ALLOC = 1'b1;
`else
  localparam bit ALLOC = 1'b0;
`endif

  // Output vector bit order: DReady W MStrobe MRW RSel WSel Busy
  localparam logic [6:0] O_DREADY = 7'b1000000;
  localparam logic [6:0] O_W      = 7'b0100000;
  localparam logic [6:0] O_MSTR   = 7'b0010000;
  localparam logic [6:0] O_MRW    = 7'b0001000;
  localparam logic [6:0] O_RSEL   = 7'b0000100;
  localparam logic [6:0] O_WSEL   = 7'b0000010;
  localparam logic [6:0] O_BUSY   = 7'b0000001;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  cache_ctrl_gen_if #(.LINE_WORDS(LINE_WORDS)) bus ();

  cache_ctrl_gen #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .LINE_WORDS (LINE_WORDS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {bus.DReady, bus.W, bus.MStrobe, bus.MRW, bus.RSel, bus.WSel, bus.Busy};
  endfunction

  // Cycles from the Strobe sample edge up to and including the DReady cycle.
  function automatic int txn_len(input bit drw, input bit hit);
    if (!drw) return hit ? 1 : 2 + LINE_WORDS * P;
    if (hit || !ALLOC) return 2 + WAIT_CYCLES;
    return 4 + LINE_WORDS * P + WAIT_CYCLES;
  endfunction

  // Refill window, k in 2..R_END: request, wait states, then data beat.
  function automatic logic [6:0] refill_vec(input int k, output int beat);
    int j;
    j    = k - 2;
    beat = -1;
    if (j % P == 0) return O_MSTR | O_BUSY;
    if (j % P == P - 1) begin
      beat = j / P;
      return O_W | O_WSEL | O_BUSY;
    end
    return O_BUSY;
  endfunction

  // Memory write starting at k=1 (hit selects the cache update).
  function automatic logic [6:0] write_vec(input bit hit, input int k);
    if (k == 1) return (hit ? O_W : 7'b0) | O_MSTR | O_MRW | O_BUSY;
    if (k <= 1 + WAIT_CYCLES) return O_MRW | O_BUSY;
    if (k == 2 + WAIT_CYCLES) return O_DREADY | O_BUSY;
    return 7'b0;
  endfunction

  function automatic logic [6:0] exp_vec(input bit drw, input bit hit, input int k,
                                         output int beat);
    beat = -1;
    if (k < 1 || k > txn_len(drw, hit)) return 7'b0;
    if (!drw) begin
      if (hit) return O_DREADY | O_BUSY;
      if (k == 1) return O_BUSY;
      if (k <= R_END) return refill_vec(k, beat);
      return O_DREADY | O_RSEL | O_BUSY;
    end
    if (hit || !ALLOC) return write_vec(hit, k);
    if (k == 1) return O_BUSY;
    if (k <= R_END) return refill_vec(k, beat);
    if (k == R_END + 1) return O_W | O_BUSY;
    return write_vec(1'b1, k - (R_END + 1));
  endfunction

  task automatic run_txn(input string name, input bit drw, input bit m, input bit v);
    bit         hit;
    int         len;
    int         beat;
    logic [6:0] e;
    logic [6:0] a;
    hit = m & v;
    len = txn_len(drw, hit);
    bus.Strobe = 1'b1;
    bus.DRW    = drw;
    @(posedge clk);
    for (int k = 1; k <= len + 1; k++) begin
      if (k > 1) @(posedge clk);
      #1;
      if (k == 1) begin
        bus.M = m;
        bus.V = v;
      end else if (drw && !hit && ALLOC && k == R_END + 2) begin
        bus.M = 1'b1;
        bus.V = 1'b1;
      end else begin
        bus.M = 1'($urandom);
        bus.V = 1'($urandom);
      end
      bus.Strobe = (k <= len) ? 1'($urandom) : 1'b0;
      bus.DRW    = 1'($urandom);
      @(negedge clk);
      e = exp_vec(drw, hit, k, beat);
      a = outs();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s cycle %0d outputs(DReady W MStrobe MRW RSel WSel Busy): got %b expected %b",
                 name, k, a, e);
      end
      if (beat >= 0) begin
        total++;
        if (bus.WordIdx !== IW'(beat)) begin
          bad++;
          $display("FAIL %s cycle %0d WordIdx: got %0d expected %0d", name, k, bus.WordIdx, beat);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    bus.Strobe = 1'b1;
    bus.DRW    = 1'b0;
    bus.M      = 1'b0;
    bus.V      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (outs() !== 7'b0) begin
      bad++;
      $display("FAIL reset outputs: got %b expected %b", outs(), 7'b0);
    end
    total++;
    if (bus.WordIdx !== '0) begin
      bad++;
      $display("FAIL reset WordIdx: got %0d expected 0", bus.WordIdx);
    end
    bus.Strobe = 1'b0;
    reset      = 1'b1;
  endtask

  task automatic test_read_hit();
    run_txn("read_hit", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_read_miss();
    run_txn("read_miss_m0", 1'b0, 1'b0, 1'b1);
    run_txn("read_miss_v0", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_write_hit();
    run_txn("write_hit", 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_write_miss();
    run_txn("write_miss", 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    bus.Strobe = 1'b1;
    bus.DRW    = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(posedge clk);
      #1;
      bus.M      = (k == 1) ? 1'b0 : 1'($urandom);
      bus.V      = 1'($urandom);
      bus.Strobe = 1'b0;
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (outs() !== 7'b0) begin
      bad++;
      $display("FAIL reset_mid outputs: got %b expected %b", outs(), 7'b0);
    end
    total++;
    if (bus.WordIdx !== '0) begin
      bad++;
      $display("FAIL reset_mid WordIdx: got %0d expected 0", bus.WordIdx);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_txn("after_reset_hit", 1'b0, 1'b1, 1'b1);
    run_txn("after_reset_miss", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_strobe_hold();
    int len;
    int pulses;
    len        = txn_len(1'b1, 1'b1);
    pulses     = 0;
    bus.Strobe = 1'b1;
    bus.DRW    = 1'b1;
    bus.M      = 1'b1;
    bus.V      = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= len; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      if (bus.DReady === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 1 || bus.DReady !== 1'b1) begin
      bad++;
      $display("FAIL strobe_hold first write DReady: got %0d pulses (last %b) expected 1 ending at cycle %0d",
               pulses, bus.DReady, len);
    end
    @(negedge clk);
    total++;
    if (outs() !== 7'b0) begin
      bad++;
      $display("FAIL strobe_hold idle visit outputs: got %b expected %b", outs(), 7'b0);
    end
    @(negedge clk);
    bus.Strobe = 1'b0;
    total++;
    if (outs() !== (O_W | O_MSTR | O_MRW | O_BUSY)) begin
      bad++;
      $display("FAIL strobe_hold second request outputs: got %b expected %b",
               outs(), O_W | O_MSTR | O_MRW | O_BUSY);
    end
    pulses = 0;
    for (int k = 2; k <= len + 1; k++) begin
      @(negedge clk);
      if (bus.DReady === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 1 || bus.Busy !== 1'b0) begin
      bad++;
      $display("FAIL strobe_hold second write: got %0d pulses Busy=%b expected 1 pulses Busy=0",
               pulses, bus.Busy);
    end
  endtask

  task automatic test_random();
    bit drw;
    bit m;
    bit v;
    for (int i = 0; i < 40; i++) begin
      drw = 1'($urandom);
      m   = ($urandom_range(0, 3) != 0);
      v   = ($urandom_range(0, 3) != 0);
      run_txn("random", drw, m, v);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_read_hit();
    test_read_miss();
    test_write_hit();
    test_write_miss();
    test_reset_mid();
    test_strobe_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
